// File: rtl/spike_tx_pkg.sv
// Shared types and defaults for the spike-address transmit path (also used on the MAC side).
// Optional spike counter on the transmitter is enabled with SPIKE_TX_COUNT_EN.
package spike_tx_pkg;

    localparam int SPIKE_ADDR_W    = 12;
    localparam int SPIKE_BASE_ADDR = 0;

    typedef logic [SPIKE_ADDR_W-1:0] spike_addr_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        CLR  = ST_CLR
    } state_t;

    // Index width for an n-entry vector; never zero so a 1-neuron build still elaborates.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Lowest-set-bit priority encoder over the pending spike vector.
module spike_prio_enc
    import spike_tx_pkg::*;
#(
    parameter int N     = 10,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     pending,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    logic found;

    always_comb begin
        idx     = '0;
        found   = 1'b0;
        any_set = |pending;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_addr_tx.sv
// Serialises a captured spike vector into source addresses, then pulses clear.
// Define SPIKE_TX_COUNT_EN to add the per-timestep spike_count output.
module spike_addr_tx
    import spike_tx_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = SPIKE_ADDR_W,
    parameter int BASE_ADDR   = SPIKE_BASE_ADDR
) (
    input  logic                   CLK_Tx,
    input  logic                   RST_n,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   spike_load,
    output logic [ADDR_W-1:0]      source_address,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic                   clear,
    output logic                   busy,
    output logic                   overflow
`ifdef SPIKE_TX_COUNT_EN
    ,
    output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

    localparam int IDX_W = idx_width(NUM_NEURONS);
    localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE_ADDR);

    state_t                 state;
    logic [NUM_NEURONS-1:0] pending;
    logic [IDX_W-1:0]       cur_idx;

    logic                   handshake;
    logic [NUM_NEURONS-1:0] pending_after;
    logic [NUM_NEURONS-1:0] enc_in;
    logic [IDX_W-1:0]       enc_idx;
    logic                   enc_any;

    assign handshake = addr_valid && addr_ready;

    // The encoder looks at next cycle's pending set, so the following address can be registered.
    always_comb begin
        pending_after = pending;
        if (handshake)
            pending_after = pending & ~(NUM_NEURONS'(1) << cur_idx);
        enc_in = (state == IDLE) ? spike_in : pending_after;
    end

    spike_prio_enc #(
        .N     (NUM_NEURONS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .pending (enc_in),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    always_ff @(posedge CLK_Tx or negedge RST_n) begin
        if (!RST_n) begin
            state          <= IDLE;
            pending        <= '0;
            cur_idx        <= '0;
            source_address <= '0;
            addr_valid     <= 1'b0;
            clear          <= 1'b0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (spike_load && (state != IDLE))
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (spike_load) begin
                        busy <= 1'b1;
                        if (enc_any) begin
                            pending        <= spike_in;
                            cur_idx        <= enc_idx;
                            source_address <= BASE_W + ADDR_W'(enc_idx);
                            addr_valid     <= 1'b1;
                            state          <= SEND;
                        end else begin
                            clear <= 1'b1;
                            state <= CLR;
                        end
                    end
                end

                SEND: begin
                    if (handshake) begin
                        pending <= pending_after;
                        if (enc_any) begin
                            cur_idx        <= enc_idx;
                            source_address <= BASE_W + ADDR_W'(enc_idx);
                        end else begin
                            addr_valid <= 1'b0;
                            clear      <= 1'b1;
                            state      <= CLR;
                        end
                    end
                end

                CLR: begin
                    clear <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_TX_COUNT_EN
    logic [$clog2(NUM_NEURONS+1)-1:0] sent_acc;

    always_ff @(posedge CLK_Tx or negedge RST_n) begin
        if (!RST_n) begin
            sent_acc    <= '0;
            spike_count <= '0;
        end else if (state == CLR) begin
            spike_count <= sent_acc;
            sent_acc    <= '0;
        end else if (handshake) begin
            sent_acc <= sent_acc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spike_addr_tx.sv
// Directed scoreboard bench for spike_addr_tx: a default instance plus a BASE_ADDR=4090 wrap instance.
module tb_spike_addr_tx;
    import spike_tx_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  spike_in, spike_in2;
    logic        spike_load, spike_load2;
    logic        addr_ready, addr_ready2;
    logic [11:0] source_address, source_address2;
    logic        addr_valid, addr_valid2;
    logic        clear, clear2;
    logic        busy, busy2;
    logic        overflow, overflow2;
`ifdef SPIKE_TX_COUNT_EN
    logic [3:0]  spike_count, spike_count2;
`endif

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    spike_addr_tx #(.NUM_NEURONS(10), .ADDR_W(12), .BASE_ADDR(0)) u_main (
        .CLK_Tx         (clk),
        .RST_n          (rst_n),
        .spike_in       (spike_in),
        .spike_load     (spike_load),
        .source_address (source_address),
        .addr_valid     (addr_valid),
        .addr_ready     (addr_ready),
        .clear          (clear),
        .busy           (busy),
        .overflow       (overflow)
`ifdef SPIKE_TX_COUNT_EN
        ,.spike_count   (spike_count)
`endif
    );

    spike_addr_tx #(.NUM_NEURONS(10), .ADDR_W(12), .BASE_ADDR(4090)) u_wrap (
        .CLK_Tx         (clk),
        .RST_n          (rst_n),
        .spike_in       (spike_in2),
        .spike_load     (spike_load2),
        .source_address (source_address2),
        .addr_valid     (addr_valid2),
        .addr_ready     (addr_ready2),
        .clear          (clear2),
        .busy           (busy2),
        .overflow       (overflow2)
`ifdef SPIKE_TX_COUNT_EN
        ,.spike_count   (spike_count2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // With ready held high, one address must be accepted every cycle.
    task automatic drain(input int n);
        int unsigned e;
        for (int k = 0; k < n; k++) begin
            check("drain_valid", {31'd0, addr_valid}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("drain_addr", {20'd0, source_address}, e);
            end else begin
                check("drain_queue_underflow", 32'd1, {31'd0, addr_valid & 1'b0});
            end
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  {20'd0, source_address}, 32'd0);
        check({tag, "_valid"}, {31'd0, addr_valid}, 32'd0);
        check({tag, "_clear"}, {31'd0, clear}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    endtask

    task automatic push_bits(input logic [9:0] v);
        for (int i = 0; i < 10; i++)
            if (v[i]) exp_q.push_back(i);
    endtask

    initial begin
        int unsigned e;
        rst_n = 1'b0;
        spike_in = '0;   spike_load = 1'b0;  addr_ready = 1'b0;
        spike_in2 = '0;  spike_load2 = 1'b0; addr_ready2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Three consecutive addresses, clear right after, then idle.
        spike_in = 10'b0000000111; spike_load = 1'b1; addr_ready = 1'b1;
        push_bits(spike_in);
        @(negedge clk);
        spike_load = 1'b0;
        drain(3);
        check("seq_clear", {31'd0, clear}, 32'd1);
        check("seq_busy_clr", {31'd0, busy}, 32'd1);
        check("seq_valid_clr", {31'd0, addr_valid}, 32'd0);
        @(negedge clk);
        check("seq_clear_off", {31'd0, clear}, 32'd0);
        check("seq_busy_off", {31'd0, busy}, 32'd0);
`ifdef SPIKE_TX_COUNT_EN
        check("seq_count", {28'd0, spike_count}, 32'd3);
`endif

        // Backpressure: address 0 held stable while ready is low.
        spike_in = 10'b1000000001; spike_load = 1'b1; addr_ready = 1'b0;
        push_bits(spike_in);
        @(negedge clk);
        spike_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", {31'd0, addr_valid}, 32'd1);
            check("hold_addr", {20'd0, source_address}, 32'd0);
            if (k < 2) @(negedge clk);
        end
        addr_ready = 1'b1;
        drain(2);
        check("hold_clear", {31'd0, clear}, 32'd1);
        @(negedge clk);
        check("hold_busy_off", {31'd0, busy}, 32'd0);

        // Empty timestep: clear only, busy for one cycle.
        spike_in = '0; spike_load = 1'b1;
        @(negedge clk);
        spike_load = 1'b0;
        check("empty_valid", {31'd0, addr_valid}, 32'd0);
        check("empty_clear", {31'd0, clear}, 32'd1);
        check("empty_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("empty_clear_off", {31'd0, clear}, 32'd0);
        check("empty_busy_off", {31'd0, busy}, 32'd0);

        // Load during SEND is dropped and sets sticky overflow.
        spike_in = 10'h3FF; spike_load = 1'b1;
        push_bits(spike_in);
        @(negedge clk);
        e = exp_q.pop_front();
        check("ovf_first_addr", {20'd0, source_address}, e);
        spike_in = 10'h001;
        @(negedge clk);
        spike_load = 1'b0;
        check("ovf_set", {31'd0, overflow}, 32'd1);
        drain(9);
        check("ovf_clear", {31'd0, clear}, 32'd1);
        @(negedge clk);
        check("ovf_busy_off", {31'd0, busy}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_queue_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        check("ovf_no_extra_valid", {31'd0, addr_valid}, 32'd0);

        // Asynchronous reset in the middle of SEND.
        spike_in = 10'h3FF; spike_load = 1'b1;
        push_bits(spike_in);
        @(negedge clk);
        spike_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            check("rst_pre_addr", {20'd0, source_address}, e);
            if (k < 2) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        exp_q.delete();
        @(negedge clk);
        check("rst_no_clear", {31'd0, clear}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        spike_in = 10'b0000000101; spike_load = 1'b1;
        push_bits(spike_in);
        @(negedge clk);
        spike_load = 1'b0;
        drain(2);
        check("rst_after_clear", {31'd0, clear}, 32'd1);
        @(negedge clk);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
`ifdef SPIKE_TX_COUNT_EN
        check("rst_after_count", {28'd0, spike_count}, 32'd2);
`endif

        // Address wrap with BASE_ADDR=4090: (4090+5)=4095, (4090+9) mod 4096 = 3.
        spike_in2 = 10'b1000100000; spike_load2 = 1'b1; addr_ready2 = 1'b1;
        @(negedge clk);
        spike_load2 = 1'b0;
        check("wrap_valid0", {31'd0, addr_valid2}, 32'd1);
        check("wrap_addr0", {20'd0, source_address2}, 32'd4095);
        @(negedge clk);
        check("wrap_valid1", {31'd0, addr_valid2}, 32'd1);
        check("wrap_addr1", {20'd0, source_address2}, 32'd3);
        @(negedge clk);
        check("wrap_clear", {31'd0, clear2}, 32'd1);
        @(negedge clk);
        check("wrap_busy_off", {31'd0, busy2}, 32'd0);
`ifdef SPIKE_TX_COUNT_EN
        check("wrap_count", {28'd0, spike_count2}, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
